// File: rtl/axis_variable_capture_pkg.sv
// Shared definitions for the AXI4-Stream status-capture blocks.
//
// Contents:
//   ST_EMPTY / ST_RUN / ST_HOLD : state encodings of the capture FSM
//   state_t                     : enum built on those encodings
//   sat_inc()                   : saturating increment for counters up to 63 bits wide
package axis_variable_capture_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    RUN   = ST_RUN,
    HOLD  = ST_HOLD
  } state_t;

  // Increment 'value' unless it already equals the all-ones pattern of a
  // 'width'-bit counter. Callers widen their counter to 64 bits on the way in
  // and truncate back to their own width on the way out.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : (value + 64'd1);
  endfunction

endpackage

// File: rtl/axis_variable_capture_timer.sv
// Stale-data timer for axis_variable_capture.
//
// Counts enabled cycles since the last clear and flags 'expired' once the
// count reaches 'limit'. A limit of 0 disables the flag.
//
// Ports:
//   aclk     in   clock, rising edge
//   aresetn  in   synchronous active-low reset
//   clr      in   zero the count and drop 'expired' (wins over everything else)
//   en       in   advance the count this cycle (saturating)
//   limit    in   CNTR_WIDTH  count at which 'expired' is set; 0 disables it
//   expired  out  sticky flag, cleared by clr, reset or limit == 0
module axis_variable_capture_timer
  import axis_variable_capture_pkg::*;
#(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic                  en,
  input  logic [CNTR_WIDTH-1:0] limit,
  output logic                  expired
);

  logic [CNTR_WIDTH-1:0] count;
  logic [CNTR_WIDTH-1:0] count_next;

  assign count_next = CNTR_WIDTH'(sat_inc(64'(count), CNTR_WIDTH));

  // The flag is set on the same edge the count reaches the limit, so it rises
  // exactly 'limit' enabled edges after the last clear. Comparing with >=
  // keeps it correct if the limit is lowered while counting.
  always_ff @(posedge aclk) begin
    if (!aresetn || clr) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (en) begin
        count <= count_next;
      end
      if (limit == '0) begin
        expired <= 1'b0;
      end else if (en && (count_next >= limit)) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_variable_capture.sv
// AXI4-Stream slave that turns sparse variable updates back into a held
// status register, with an update counter, change pulse, stale timeout and a
// hold control that freezes capture and backpressures the source.
//
// Ports:
//   aclk           in   clock, rising edge
//   aresetn        in   synchronous active-low reset
//   cfg_hold       in   1 freezes capture and drops s_axis_tready
//   cfg_timeout    in   CNTR_WIDTH  idle RUN cycles before sts_stale; 0 disables
//   s_axis_tdata   in   AXIS_TDATA_WIDTH  incoming value
//   s_axis_tvalid  in   source valid
//   s_axis_tready  out  registered ready
//   sts_data       out  AXIS_TDATA_WIDTH  last accepted value
//   sts_valid      out  at least one word accepted since reset
//   sts_changed    out  one-cycle pulse: accepted word differed or was the first
//   sts_count      out  UPD_WIDTH  accepted words, saturating
//   sts_stale      out  no accept for cfg_timeout RUN cycles
module axis_variable_capture
  import axis_variable_capture_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int UPD_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_hold,
  input  logic [CNTR_WIDTH-1:0]       cfg_timeout,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] sts_data,
  output logic                        sts_valid,
  output logic                        sts_changed,
  output logic [UPD_WIDTH-1:0]        sts_count,
  output logic                        sts_stale
);

  state_t state;
  logic   accept;
  logic   timer_clr;
  logic   timer_en;

  assign accept = s_axis_tvalid & s_axis_tready;

  // The timer is zeroed by every accept and held at zero while nothing has
  // been captured; it only runs in RUN, which also freezes it in HOLD.
  assign timer_clr = accept || (state == EMPTY);
  assign timer_en  = (state == RUN) && !accept;

  axis_variable_capture_timer #(
    .CNTR_WIDTH(CNTR_WIDTH)
  ) u_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (timer_clr),
    .en      (timer_en),
    .limit   (cfg_timeout),
    .expired (sts_stale)
  );

  // FSM plus capture registers. Ready is computed from the current state, so
  // leaving HOLD costs one extra cycle before the source sees ready again,
  // while a handshake already in flight on the hold-sampling edge is kept.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= EMPTY;
      s_axis_tready <= 1'b0;
      sts_data      <= '0;
      sts_valid     <= 1'b0;
      sts_changed   <= 1'b0;
      sts_count     <= '0;
    end else begin
      s_axis_tready <= (state != HOLD) && !cfg_hold;

      unique case (state)
        EMPTY: begin
          if (cfg_hold) begin
            state <= HOLD;
          end else if (accept) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (cfg_hold) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!cfg_hold) begin
            state <= sts_valid ? RUN : EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase

      // The first word after reset always counts as a change, whatever the
      // cleared data register happens to hold.
      sts_changed <= accept && (!sts_valid || (s_axis_tdata != sts_data));

      if (accept) begin
        sts_data  <= s_axis_tdata;
        sts_valid <= 1'b1;
        sts_count <= UPD_WIDTH'(sat_inc(64'(sts_count), UPD_WIDTH));
      end
    end
  end

endmodule

// File: tb/tb_axis_variable_capture.sv
// Self-checking bench for axis_variable_capture: a table of per-edge vectors
// for the capture, change-detect, hold and reset behaviour, followed by
// hand-written sequences for the stale timer and counter saturation (the
// latter on a second instance with a 4-bit update counter).
module tb_axis_variable_capture;

  logic        aclk;
  logic        aresetn;
  logic        cfg_hold;
  logic [31:0] cfg_timeout;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;

  logic        s_axis_tready;
  logic [31:0] sts_data;
  logic        sts_valid;
  logic        sts_changed;
  logic [15:0] sts_count;
  logic        sts_stale;

  logic        tready4;
  logic [31:0] data4;
  logic        valid4;
  logic        changed4;
  logic [3:0]  count4;
  logic        stale4;

  int num_checks = 0;
  int num_fail   = 0;

  axis_variable_capture dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_hold      (cfg_hold),
    .cfg_timeout   (cfg_timeout),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .sts_data      (sts_data),
    .sts_valid     (sts_valid),
    .sts_changed   (sts_changed),
    .sts_count     (sts_count),
    .sts_stale     (sts_stale)
  );

  axis_variable_capture #(
    .UPD_WIDTH(4)
  ) dut4 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_hold      (cfg_hold),
    .cfg_timeout   (cfg_timeout),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (tready4),
    .sts_data      (data4),
    .sts_valid     (valid4),
    .sts_changed   (changed4),
    .sts_count     (count4),
    .sts_stale     (stale4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        rstn;
    logic        hold;
    logic        valid;
    logic [31:0] data;
    logic        exp_ready;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_changed;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rstn, input logic hold, input logic valid,
                         input logic [31:0] data, input logic exp_ready,
                         input logic [31:0] exp_data, input logic exp_valid,
                         input logic exp_changed, input logic [15:0] exp_count);
    vec_t v;
    v.rstn = rstn; v.hold = hold; v.valid = valid; v.data = data;
    v.exp_ready = exp_ready; v.exp_data = exp_data; v.exp_valid = exp_valid;
    v.exp_changed = exp_changed; v.exp_count = exp_count;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one edge and settle away from it before anyone samples.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    aresetn       = v.rstn;
    cfg_hold      = v.hold;
    s_axis_tvalid = v.valid;
    s_axis_tdata  = v.data;
    tick();
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check($sformatf("v%0d_tready", idx),  64'(s_axis_tready), 64'(v.exp_ready));
    check($sformatf("v%0d_data", idx),    64'(sts_data),      64'(v.exp_data));
    check($sformatf("v%0d_valid", idx),   64'(sts_valid),     64'(v.exp_valid));
    check($sformatf("v%0d_changed", idx), 64'(sts_changed),   64'(v.exp_changed));
    check($sformatf("v%0d_count", idx),   64'(sts_count),     64'(v.exp_count));
    check($sformatf("v%0d_stale", idx),   64'(sts_stale),     64'd0);
  endtask

  initial begin
    logic early;
    logic seen;

    aresetn       = 1'b0;
    cfg_hold      = 1'b0;
    cfg_timeout   = 32'd0;
    s_axis_tdata  = 32'd0;
    s_axis_tvalid = 1'b0;

    // rstn hold valid data | ready data valid changed count
    add_vec(0, 0, 0, 32'h00, 0, 32'h00, 0, 0, 0);
    add_vec(0, 0, 1, 32'hA5, 0, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'hA5, 1, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'hA5, 1, 32'hA5, 1, 1, 1);
    add_vec(1, 0, 0, 32'h00, 1, 32'hA5, 1, 0, 1);
    add_vec(0, 0, 1, 32'h09, 0, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'h05, 1, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'h05, 1, 32'h05, 1, 1, 1);
    add_vec(1, 0, 1, 32'h05, 1, 32'h05, 1, 0, 2);
    add_vec(1, 0, 1, 32'h07, 1, 32'h07, 1, 1, 3);
    add_vec(1, 0, 1, 32'h07, 1, 32'h07, 1, 0, 4);
    add_vec(0, 0, 1, 32'h08, 0, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'h07, 1, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'h07, 1, 32'h07, 1, 1, 1);
    add_vec(1, 0, 1, 32'h07, 1, 32'h07, 1, 0, 2);
    add_vec(1, 1, 1, 32'h55, 0, 32'h55, 1, 1, 3);
    add_vec(1, 1, 1, 32'h55, 0, 32'h55, 1, 0, 3);
    add_vec(1, 1, 1, 32'h66, 0, 32'h55, 1, 0, 3);
    add_vec(1, 0, 1, 32'h66, 0, 32'h55, 1, 0, 3);
    add_vec(1, 0, 1, 32'h66, 1, 32'h55, 1, 0, 3);
    add_vec(1, 0, 1, 32'h66, 1, 32'h66, 1, 1, 4);
    add_vec(1, 0, 0, 32'h00, 1, 32'h66, 1, 0, 4);
    add_vec(0, 0, 0, 32'h00, 0, 32'h00, 0, 0, 0);
    add_vec(1, 1, 1, 32'h11, 0, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'h11, 0, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'h11, 1, 32'h00, 0, 0, 0);
    add_vec(1, 0, 1, 32'h11, 1, 32'h11, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Stale timer: rises exactly cfg_timeout edges after the last accept.
    aresetn = 1'b0; s_axis_tvalid = 1'b0; cfg_hold = 1'b0;
    tick();
    cfg_timeout   = 32'd10;
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0A;
    tick();
    tick();
    check("stale_first_accept_count", 64'(sts_count), 64'd1);
    s_axis_tvalid = 1'b0;
    early = 1'b0;
    for (int k = 1; k < 10; k++) begin
      tick();
      if (sts_stale) early = 1'b1;
    end
    check("stale_before_T", 64'(early), 64'd0);
    tick();
    check("stale_at_T", 64'(sts_stale), 64'd1);

    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h22;
    tick();
    s_axis_tvalid = 1'b0;
    check("stale_cleared_by_accept", 64'(sts_stale), 64'd0);
    for (int k = 0; k < 10; k++) tick();
    check("stale_again", 64'(sts_stale), 64'd1);
    cfg_timeout = 32'd0;
    tick();
    check("stale_cleared_by_zero_timeout", 64'(sts_stale), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (sts_stale) seen = 1'b1;
    end
    check("stale_disabled_1000", 64'(seen), 64'd0);

    // Accept on the edge the timer would expire: the accept wins.
    cfg_timeout   = 32'd3;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h33;
    tick();
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h34;
    tick();
    s_axis_tvalid = 1'b0;
    check("stale_accept_wins", 64'(sts_stale), 64'd0);
    tick();
    tick();
    check("stale_timer_restarted", 64'(sts_stale), 64'd0);
    tick();
    check("stale_after_restart", 64'(sts_stale), 64'd1);

    // Counter saturation on the 4-bit instance, 20 consecutive accepts.
    cfg_timeout   = 32'd0;
    aresetn       = 1'b0;
    tick();
    aresetn       = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd0;
    tick();
    for (int i = 1; i <= 20; i++) begin
      s_axis_tdata = 32'(i);
      tick();
      check($sformatf("sat_count4_%0d", i), 64'(count4), (i > 15) ? 64'd15 : 64'(i));
    end
    s_axis_tvalid = 1'b0;
    check("sat_count16", 64'(sts_count), 64'd20);
    check("sat_data4", 64'(data4), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/axis_variable_capture.md
# axis_variable_capture

Single-clock AXI4-Stream slave that captures the latest word of a slowly changing variable stream into a held status register. It is the receive-side counterpart of the config-variable stream emitters: those turn a register into sparse AXIS updates, and this block turns sparse AXIS updates back into a register. It adds an update counter, a change pulse, a stale-data timeout and a freeze (hold) control. It sits in the aclk domain between a variable stream and status or config consumers.

## Interface
- AXIS_TDATA_WIDTH, 32, width of stream data and captured value
- CNTR_WIDTH, 32, width of the stale-timeout counter and `cfg_timeout`
- UPD_WIDTH, 16, width of the accepted-update counter
- aclk  input  1  system clock; everything is on the rising edge
- aresetn  input  1  reset, synchronous, active-low
- cfg_hold  input  1  1 freezes capture and backpressures the stream
- cfg_timeout  input  CNTR_WIDTH  idle cycles before `sts_stale` asserts; 0 disables the timeout
- s_axis_tdata  input  AXIS_TDATA_WIDTH  incoming variable value
- s_axis_tvalid  input  1  source valid
- s_axis_tready  output  1  registered ready
- sts_data  output  AXIS_TDATA_WIDTH  last accepted value
- sts_valid  output  1  at least one word accepted since reset
- sts_changed  output  1  one-cycle pulse when an accepted word differs from the previous value (or is the first word)
- sts_count  output  UPD_WIDTH  number of accepted words, saturating
- sts_stale  output  1  no word accepted for `cfg_timeout` RUN cycles

## Operation
- States are EMPTY, RUN and HOLD. Reset enters EMPTY.
- EMPTY → RUN on the first accepted word.
- EMPTY or RUN → HOLD when `cfg_hold` is sampled 1.
- HOLD → RUN when `cfg_hold` is sampled 0 and `sts_valid` is 1; otherwise HOLD → EMPTY.
- Accept: `s_axis_tvalid & s_axis_tready` at an edge. On that edge:
  - `sts_data` takes `tdata`.
  - `sts_valid` goes to 1.
  - `sts_count` increments; it saturates at all-ones and never wraps.
  - The timeout counter clears.
  - `sts_stale` clears.
- `sts_changed`: registered. It is 1 for the cycle after an accept when `tdata != sts_data` (old value), or when the accept is the first since reset. Otherwise 0.
- `s_axis_tready`: registered. Next value is 1 in EMPTY/RUN when `cfg_hold` is 0, else 0.
- Stale timer: increments each cycle in RUN with no accept, saturating at all-ones.
  - `sts_stale` is set when the counter reaches `cfg_timeout` and `cfg_timeout != 0`.
  - The timer is frozen in HOLD and held at 0 in EMPTY.
  - Writing `cfg_timeout = 0` clears `sts_stale` on the next edge.
- No data path back to the source; `tdata` is never buffered beyond `sts_data`.

## Timing
- Reset values: `s_axis_tready` 0, `sts_data` 0, `sts_valid` 0, `sts_changed` 0, `sts_count` 0, `sts_stale` 0, timer 0, state EMPTY.
- `s_axis_tready` rises at the first edge with `aresetn`=1 (one cycle after reset release).
- Capture latency: `sts_data`, `sts_count` and `sts_valid` update at the accept edge. `sts_changed` is high the cycle after the accept edge.
- Full throughput: back-to-back accepts every cycle in RUN. `sts_changed` can stay high on consecutive cycles.
- `cfg_hold` rising, sampled at edge N: ready is still 1 during cycle N-1→N, so a handshake completing at edge N is captured. Ready is 0 from edge N on.
- `cfg_hold` falling, sampled at edge N: ready is 1 from edge N+1 on.
- Accept and timer expiry on the same edge: the accept wins; stale stays 0 and the timer clears.
- Reset mid-stream: the held word is dropped and all outputs return to reset values at that edge.
- Stale assertion: with T = `cfg_timeout`, `sts_stale` rises exactly T edges after the last accept edge, if no accept occurs and the block stays in RUN.

## Structure
- Shared package: state encoding localparams (EMPTY, RUN, HOLD) and the saturating-increment helper function. These are reused by other status-capture blocks.
- One sub-module, `axis_variable_capture_timer`, handles the stale timer.
  - Inputs: `aclk`, `aresetn`, `clr`, `en`, `limit`.
  - Output: `expired`.
  - Parameter: CNTR_WIDTH.
- The top level holds the FSM, data register, counter and change detect.

## Test plan
- Reset, then `tvalid`=1 with `tdata`=0x0000_00A5. Required response:
  - `tready` rises 1 cycle after reset release.
  - After the accept edge: `sts_data`=0xA5, `sts_valid`=1, `sts_count`=1.
  - `sts_changed` pulses once the following cycle.
- Words 5, 5, 7 on consecutive cycles → `sts_count` 1, 2, 3; `sts_changed` pattern 1, 0, 1; `sts_data`=7.
- `cfg_timeout`=10, one accept, then idle:
  - `sts_stale` rises exactly 10 edges after the accept.
  - The next word clears it at the accept edge.
  - With `cfg_timeout`=0, it never asserts over 1000 cycles.
- `cfg_hold`=1 while `tvalid` is held with 0x55:
  - The word whose handshake completes at the hold-sampling edge is captured.
  - `tready`=0 afterwards, and `sts_data`/`sts_count` stay frozen.
  - On release, `tready` returns 1 cycle later and the pending word is accepted.
- UPD_WIDTH=4 with 20 accepts → `sts_count` stops at 15 and never wraps.
- Assert `aresetn`=0 mid-burst → all outputs and `tready` read reset values at the next edge. The following words are treated as first words (`sts_changed`=1).
